// File: rtl/sequenciador_ciclo_if.sv
// rtl/sequenciador_ciclo_if.sv - sequencer-to-datapath/memory signal bundle
// Purpose: groups every non-clock, non-reset signal of sequenciador_ciclo.
// Ports (slave = sequencer side):
//   in : estado_pc, desvio_valido, endereco_desvio, mem_pronta, stall, halt
//   out: pc_proximo, pc_escreve, busca_req, mem_req, reg_escreve, fase,
//        instr_contador, parado
interface sequenciador_ciclo_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] estado_pc;
  logic             desvio_valido;
  logic [WIDTH-1:0] endereco_desvio;
  logic             mem_pronta;
  logic             stall;
  logic             halt;
  logic [WIDTH-1:0] pc_proximo;
  logic             pc_escreve;
  logic             busca_req;
  logic             mem_req;
  logic             reg_escreve;
  logic [2:0]       fase;
  logic [WIDTH-1:0] instr_contador;
  logic             parado;

  modport slave (
    input  estado_pc, desvio_valido, endereco_desvio, mem_pronta, stall, halt,
    output pc_proximo, pc_escreve, busca_req, mem_req, reg_escreve, fase,
           instr_contador, parado
  );

  modport master (
    output estado_pc, desvio_valido, endereco_desvio, mem_pronta, stall, halt,
    input  pc_proximo, pc_escreve, busca_req, mem_req, reg_escreve, fase,
           instr_contador, parado
  );
endinterface

// File: rtl/sequenciador_ciclo.sv
// rtl/sequenciador_ciclo.sv - multi-cycle instruction phase sequencer
// Purpose: steps BUSCA/DECODIFICA/EXECUTA/MEMORIA/ESCRITA, raises fetch and
// data requests, and commits the next PC plus a register write once per
// instruction. halt at commit parks the sequencer in PARADO until reset.
// Ports:
//   clock  in  rising-edge clock
//   reset  in  asynchronous, active-high
//   bus    sequenciador_ciclo_if.slave (PC, branch, memory handshake, strobes,
//          phase, committed-instruction count, parked flag)
module sequenciador_ciclo #(
  parameter int WIDTH     = 32,
  parameter int PC_INC    = 1,
  parameter int PC_RESET  = 1,
  parameter int FETCH_CYC = 2,
  parameter int DEC_CYC   = 2,
  parameter int EXEC_CYC  = 2,
  parameter int MEM_CYC   = 2,
  parameter int WB_CYC    = 2
) (
  input logic                 clock,
  input logic                 reset,
  sequenciador_ciclo_if.slave bus
);

  localparam int MAX_AB  = (FETCH_CYC > DEC_CYC) ? FETCH_CYC : DEC_CYC;
  localparam int MAX_CD  = (EXEC_CYC > MEM_CYC) ? EXEC_CYC : MEM_CYC;
  localparam int MAX_ABC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int MAXC    = (MAX_ABC > WB_CYC) ? MAX_ABC : WB_CYC;
  localparam int CW      = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);

  typedef enum logic [2:0] {
    BUSCA      = 3'd0,
    DECODIFICA = 3'd1,
    EXECUTA    = 3'd2,
    MEMORIA    = 3'd3,
    ESCRITA    = 3'd4,
    PARADO     = 3'd5
  } fase_t;

  fase_t          fase_r, fase_n;
  logic [CW-1:0]  cnt_r, cnt_n, ultimo;
  logic           espera_mem;
  logic           captura_desvio;
  logic           commit;

  logic [WIDTH-1:0] pc_proximo_r;
  logic [WIDTH-1:0] instr_contador_r;
  logic [WIDTH-1:0] alvo_r;
  logic             desvio_r;
  logic             pc_escreve_r;
  logic             reg_escreve_r;
  logic             parado_r;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fase_r <= BUSCA;
      cnt_r  <= '0;
    end else begin
      fase_r <= fase_n;
      cnt_r  <= cnt_n;
    end
  end

  always_comb begin
    fase_n         = fase_r;
    cnt_n          = cnt_r;
    ultimo         = '0;
    espera_mem     = 1'b0;
    captura_desvio = 1'b0;
    commit         = 1'b0;

    case (fase_r)
      BUSCA:      begin ultimo = CW'(FETCH_CYC - 1); espera_mem = 1'b1; end
      DECODIFICA: ultimo = CW'(DEC_CYC - 1);
      EXECUTA:    ultimo = CW'(EXEC_CYC - 1);
      MEMORIA:    begin ultimo = CW'(MEM_CYC - 1); espera_mem = 1'b1; end
      ESCRITA:    ultimo = CW'(WB_CYC - 1);
      default:    ultimo = '0;
    endcase

    // stall freezes everything; PARADO is only left through reset.
    if (fase_r != PARADO && !bus.stall) begin
      if (cnt_r == ultimo && (!espera_mem || bus.mem_pronta)) begin
        cnt_n = '0;
        case (fase_r)
          BUSCA:      fase_n = DECODIFICA;
          DECODIFICA: fase_n = EXECUTA;
          EXECUTA:    begin fase_n = MEMORIA; captura_desvio = 1'b1; end
          MEMORIA:    fase_n = ESCRITA;
          ESCRITA:    begin fase_n = bus.halt ? PARADO : BUSCA; commit = 1'b1; end
          default:    fase_n = fase_r;
        endcase
      end else if (cnt_r != ultimo) begin
        // Saturates at the last count while a memory phase waits for mem_pronta.
        cnt_n = cnt_r + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_proximo_r     <= WIDTH'(PC_RESET);
      instr_contador_r <= '0;
      alvo_r           <= '0;
      desvio_r         <= 1'b0;
      pc_escreve_r     <= 1'b0;
      reg_escreve_r    <= 1'b0;
      parado_r         <= 1'b0;
    end else begin
      pc_escreve_r  <= commit;
      reg_escreve_r <= commit;
      parado_r      <= (fase_n == PARADO);
      if (captura_desvio) begin
        desvio_r <= bus.desvio_valido;
        alvo_r   <= bus.endereco_desvio;
      end
      if (commit) begin
        pc_proximo_r     <= desvio_r ? alvo_r : bus.estado_pc + WIDTH'(PC_INC);
        instr_contador_r <= instr_contador_r + WIDTH'(1);
        desvio_r         <= 1'b0;
      end
    end
  end

  assign bus.pc_proximo     = pc_proximo_r;
  assign bus.pc_escreve     = pc_escreve_r;
  assign bus.reg_escreve    = reg_escreve_r;
  assign bus.instr_contador = instr_contador_r;
  assign bus.parado         = parado_r;
  assign bus.fase           = fase_r;
  assign bus.busca_req      = (fase_r == BUSCA) && !bus.stall;
  assign bus.mem_req        = (fase_r == MEMORIA) && !bus.stall;

endmodule

// File: tb/tb_sequenciador_ciclo.sv
// tb/tb_sequenciador_ciclo.sv - scoreboard bench for sequenciador_ciclo
module tb_sequenciador_ciclo;

  localparam int LEN [5] = '{2, 2, 2, 2, 2};

  logic clock;
  logic reset;
  int   total;
  int   bad;
  bit   mon_en;

  sequenciador_ciclo_if #(.WIDTH(32)) bus ();

  sequenciador_ciclo #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: phase index plus non-stalled cycles spent in it.
  int          m_phase;
  int          m_w;
  bit          m_br;
  logic [31:0] m_tgt;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_strobe;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_phase  = 0;
      m_w      = 0;
      m_br     = 0;
      m_tgt    = 0;
      m_pc     = 32'd1;
      m_cnt    = 0;
      m_strobe = 0;
      exp_q.delete();
    end else begin
      m_strobe = 0;
      if (m_phase != 5 && !bus.stall) begin
        m_w++;
        if (m_w >= LEN[m_phase] && (!(m_phase == 0 || m_phase == 3) || bus.mem_pronta)) begin
          if (m_phase == 2) begin
            m_br  = bus.desvio_valido;
            m_tgt = bus.endereco_desvio;
          end
          if (m_phase == 4) begin
            m_pc     = m_br ? m_tgt : bus.estado_pc + 32'd1;
            m_cnt    = m_cnt + 32'd1;
            m_strobe = 1;
            exp_q.push_back(m_pc);
            m_br     = 0;
            m_phase  = bus.halt ? 5 : 0;
          end else begin
            m_phase++;
          end
          m_w = 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (mon_en && !reset) begin
      chk("fase", 32'(bus.fase), 32'(m_phase));
      chk("busca_req", 32'(bus.busca_req), 32'(m_phase == 0 && !bus.stall));
      chk("mem_req", 32'(bus.mem_req), 32'(m_phase == 3 && !bus.stall));
      chk("parado", 32'(bus.parado), 32'(m_phase == 5));
      chk("pc_escreve", 32'(bus.pc_escreve), 32'(m_strobe));
      chk("reg_escreve", 32'(bus.reg_escreve), 32'(m_strobe));
      chk("instr_contador", bus.instr_contador, m_cnt);
      if (bus.pc_escreve) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL commit_sb actual=unexpected_strobe required=no_strobe t=%0t", $time);
        end else begin
          chk("commit_pc", bus.pc_proximo, exp_q.pop_front());
        end
      end
    end
  end

  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_fase", 32'(bus.fase), 32'd0);
    chk("rst_pc_proximo", bus.pc_proximo, 32'd1);
    chk("rst_pc_escreve", 32'(bus.pc_escreve), 32'd0);
    chk("rst_reg_escreve", 32'(bus.reg_escreve), 32'd0);
    chk("rst_instr_contador", bus.instr_contador, 32'd0);
    chk("rst_parado", 32'(bus.parado), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic wait_commit();
    logic [31:0] c;
    bit          seen;
    c    = m_cnt;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clock);
      #1;
      if (m_cnt != c) seen = 1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL wait_commit actual=timeout required=commit t=%0t", $time);
    end
  endtask

  task automatic wait_phase(input int p);
    bit seen;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clock);
      #1;
      if (m_phase == p) seen = 1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL wait_phase actual=timeout required=phase%0d t=%0t", p, $time);
    end
  endtask

  initial begin
    total               = 0;
    bad                 = 0;
    mon_en              = 0;
    reset               = 1'b0;
    bus.estado_pc       = 32'd5;
    bus.desvio_valido   = 1'b0;
    bus.endereco_desvio = 32'd0;
    bus.mem_pronta      = 1'b1;
    bus.stall           = 1'b0;
    bus.halt            = 1'b0;
    #1;
    pulse_reset();

    // Back-to-back instructions, no waits.
    wait_commit();
    chk("first_pc", bus.pc_proximo, 32'd6);
    wait_commit();

    // Taken branch, then sequential again.
    bus.desvio_valido   = 1'b1;
    bus.endereco_desvio = 32'h40;
    wait_commit();
    wait_commit();
    bus.desvio_valido = 1'b0;
    wait_commit();
    wait_commit();
    chk("after_branch_pc", bus.pc_proximo, 32'd6);

    // Memory not ready for 4 cycles inside MEMORIA.
    wait_phase(3);
    bus.mem_pronta = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    bus.mem_pronta = 1'b1;
    wait_commit();

    // Stall 3 cycles inside DECODIFICA.
    wait_phase(1);
    bus.stall = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    bus.stall = 1'b0;
    wait_commit();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      @(posedge clock);
      #1;
      bus.mem_pronta      = ($urandom_range(0, 3) != 0);
      bus.stall           = ($urandom_range(0, 6) == 0);
      bus.desvio_valido   = $urandom_range(0, 1) != 0;
      bus.endereco_desvio = $urandom;
      bus.estado_pc       = $urandom;
    end

    // PC wrap, then halt at commit.
    bus.mem_pronta    = 1'b1;
    bus.stall         = 1'b0;
    bus.desvio_valido = 1'b0;
    bus.estado_pc     = 32'hFFFF_FFFF;
    wait_commit();
    bus.halt = 1'b1;
    wait_commit();
    chk("wrap_pc", bus.pc_proximo, 32'd0);
    chk("halt_strobe", 32'(bus.pc_escreve), 32'd1);
    repeat (20) @(posedge clock);
    #1;
    chk("halt_fase", 32'(bus.fase), 32'd5);
    chk("halt_parado", 32'(bus.parado), 32'd1);
    bus.halt      = 1'b0;
    bus.estado_pc = 32'd5;

    // Leave PARADO by reset, then reset again mid-EXECUTA.
    pulse_reset();
    wait_phase(2);
    pulse_reset();
    wait_commit();
    chk("post_reset_count", bus.instr_contador, 32'd1);
    chk("post_reset_pc", bus.pc_proximo, 32'd6);
    repeat (3) @(posedge clock);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
